// File: rtl/npu_chk_pkg.sv
// -----------------------------------------------------------------------------
// npu_chk_pkg
//   Shared types and helpers for the NPU output checker.
//   - chk_state_e : checker FSM state encoding
//   - calc_dw()   : vector width derived from element width and elements/vector
// -----------------------------------------------------------------------------
package npu_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREFETCH,
    ST_RUN,
    ST_DONE
  } chk_state_e;

  function automatic int calc_dw(input int ew, input int dotw);
    return ew * dotw;
  endfunction

endpackage : npu_chk_pkg

// File: rtl/npu_chk_gold_ram.sv
// -----------------------------------------------------------------------------
// npu_chk_gold_ram
//   Simple dual-port golden-vector RAM: one write port, one read port with a
//   single registered read stage.
// Ports:
//   clk      in  clock
//   wr_en    in  write strobe
//   wr_addr  in  AW   write address
//   wr_data  in  DW   write data
//   rd_addr  in  AW   read address, sampled every rising edge
//   rd_data  out DW   registered read data (read-before-write on a collision)
// -----------------------------------------------------------------------------
module npu_chk_gold_ram #(
  parameter int DEPTH = 512,
  parameter int AW    = 9,
  parameter int DW    = 320
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // NOTE: the array has no reset; golden contents must survive a reset and a
  // resettable array would not map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule : npu_chk_gold_ram

// File: rtl/npu_out_checker.sv
// -----------------------------------------------------------------------------
// npu_out_checker
//   Drains both NPU output loader lanes in lockstep and compares every popped
//   vector against a preloaded golden memory. Reports mismatch count, first bad
//   index, runtime cycles and pass/fail.
//
// Optional feature macro: NPU_OUT_CHECK_TIMEOUT_EN
//   Defined   : watchdog ends a run after TIMEOUT_CYC consecutive RUN cycles
//               without a pop (o_timeout=1, o_pass=0).
//   Undefined : no watchdog, o_timeout tied low.
//
// Ports:
//   clk, rst (async, active-low)
//   i_gold_wr_en/addr/din : golden write port, honoured only when not busy
//   i_start               : one-cycle run start (ignored while busy)
//   i_num_outputs         : vectors to check, sampled at start, clamped
//   i_out_rdy0/1, i_out_dout0/1 : FWFT loader heads
//   o_out_rd_en0/1        : pop strobes (combinational, both lanes equal)
//   o_busy, o_done, o_pass, o_timeout : registered status
//   o_mismatch_cnt, o_first_bad, o_cycles : registered results
// -----------------------------------------------------------------------------
module npu_out_checker
  import npu_chk_pkg::*;
#(
  parameter int  EW          = 8,
  parameter int  DOTW        = 40,
  parameter int  GOLD_DEPTH  = 512,
  parameter int  GOLD_AW     = 9,
  parameter int  CYCW        = 32,
  parameter int  TIMEOUT_CYC = 65535,
  localparam int DW          = calc_dw(EW, DOTW)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_gold_wr_en,
  input  logic [GOLD_AW-1:0] i_gold_wr_addr,
  input  logic [DW-1:0]      i_gold_wr_din,
  input  logic               i_start,
  input  logic [GOLD_AW:0]   i_num_outputs,
  input  logic               i_out_rdy0,
  input  logic               i_out_rdy1,
  input  logic [DW-1:0]      i_out_dout0,
  input  logic [DW-1:0]      i_out_dout1,
  output logic               o_out_rd_en0,
  output logic               o_out_rd_en1,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_pass,
  output logic               o_timeout,
  output logic [CYCW-1:0]    o_mismatch_cnt,
  output logic [GOLD_AW-1:0] o_first_bad,
  output logic [CYCW-1:0]    o_cycles
);

  localparam logic [GOLD_AW:0]   N_MAX   = (GOLD_AW+1)'(GOLD_DEPTH);
  localparam logic [GOLD_AW:0]   N_ONE   = (GOLD_AW+1)'(1);
  localparam logic [GOLD_AW-1:0] IDX_ONE = GOLD_AW'(1);
  localparam logic [CYCW-1:0]    CYC_ONE = CYCW'(1);

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("npu_out_checker: TIMEOUT_CYC must be at least 1");
  end

  chk_state_e         state;
  logic [GOLD_AW:0]   n_q;
  logic [GOLD_AW-1:0] idx;
  logic [DW-1:0]      gold_q;

  logic               pop;
  logic               vec_ok;
  logic               last_pop;
  logic               gold_we;
  logic [GOLD_AW-1:0] rd_addr;
  logic [GOLD_AW:0]   n_start;

`ifdef NPU_OUT_CHECK_TIMEOUT_EN
  localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);
  logic [WD_W-1:0] wd_cnt;
`else
  assign o_timeout = 1'b0;
`endif

  npu_chk_gold_ram #(
    .DEPTH (GOLD_DEPTH),
    .AW    (GOLD_AW),
    .DW    (DW)
  ) u_gold_ram (
    .clk     (clk),
    .wr_en   (gold_we),
    .wr_addr (i_gold_wr_addr),
    .wr_data (i_gold_wr_din),
    .rd_addr (rd_addr),
    .rd_data (gold_q)
  );

  // NOTE: every signal gets a default before any branch so no latch is inferred.
  always_comb begin
    pop      = 1'b0;
    rd_addr  = '0;
    gold_we  = 1'b0;
    n_start  = (i_num_outputs > N_MAX) ? N_MAX : i_num_outputs;
    vec_ok   = (i_out_dout0 == gold_q) && (i_out_dout1 == gold_q);
    unique case (state)
      ST_IDLE, ST_DONE: begin
        gold_we = i_gold_wr_en;
      end
      ST_PREFETCH: begin
        rd_addr = idx;
      end
      ST_RUN: begin
        pop = i_out_rdy0 & i_out_rdy1;
        // Look one vector ahead on a pop so the next head compares next cycle.
        rd_addr = pop ? idx + IDX_ONE : idx;
      end
      default: ;
    endcase
    last_pop = pop && ({1'b0, idx} == (n_q - N_ONE));
  end

  assign o_out_rd_en0 = pop;
  assign o_out_rd_en1 = pop;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      n_q            <= '0;
      idx            <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_pass         <= 1'b0;
      o_mismatch_cnt <= '0;
      o_first_bad    <= '0;
      o_cycles       <= '0;
`ifdef NPU_OUT_CHECK_TIMEOUT_EN
      o_timeout      <= 1'b0;
      wd_cnt         <= '0;
`endif
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            state          <= ST_PREFETCH;
            n_q            <= n_start;
            idx            <= '0;
            o_busy         <= 1'b1;
            o_done         <= 1'b0;
            o_pass         <= 1'b0;
            o_mismatch_cnt <= '0;
            o_first_bad    <= '0;
            // The start edge itself is the first counted cycle.
            o_cycles       <= CYC_ONE;
`ifdef NPU_OUT_CHECK_TIMEOUT_EN
            o_timeout      <= 1'b0;
            wd_cnt         <= '0;
`endif
          end
        end

        ST_PREFETCH: begin
          if (o_cycles != '1) o_cycles <= o_cycles + CYC_ONE;
          if (n_q == '0) begin
            state  <= ST_DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
            o_pass <= 1'b1;
          end else begin
            state <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (o_cycles != '1) o_cycles <= o_cycles + CYC_ONE;
          if (pop) begin
            idx <= idx + IDX_ONE;
`ifdef NPU_OUT_CHECK_TIMEOUT_EN
            wd_cnt <= '0;
`endif
            if (!vec_ok) begin
              if (o_mismatch_cnt != '1) o_mismatch_cnt <= o_mismatch_cnt + CYC_ONE;
              if (o_mismatch_cnt == '0) o_first_bad <= idx;
            end
            if (last_pop) begin
              state  <= ST_DONE;
              o_busy <= 1'b0;
              o_done <= 1'b1;
              // Pass reflects the count including this final pop.
              o_pass <= vec_ok && (o_mismatch_cnt == '0);
            end
          end
`ifdef NPU_OUT_CHECK_TIMEOUT_EN
          else if (wd_cnt == WD_LAST) begin
            state     <= ST_DONE;
            o_busy    <= 1'b0;
            o_done    <= 1'b1;
            o_pass    <= 1'b0;
            o_timeout <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + WD_ONE;
          end
`endif
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule : npu_out_checker

// File: tb/tb_npu_out_checker.sv
// -----------------------------------------------------------------------------
// tb_npu_out_checker
//   Self-checking bench for npu_out_checker. Lanes are modelled as FWFT queues
//   whose readiness follows a per-run schedule; expected pops, mismatches,
//   first bad index, cycle count and timeout are derived from that schedule
//   and a golden array kept in the bench.
// -----------------------------------------------------------------------------
module tb_npu_out_checker;
  import npu_chk_pkg::*;

  localparam int EW         = 8;
  localparam int DOTW       = 40;
  localparam int DW         = calc_dw(EW, DOTW);
  localparam int GOLD_DEPTH = 512;
  localparam int GOLD_AW    = 9;
  localparam int CYCW       = 32;
  localparam int TB_TIMEOUT = 16;
  localparam int RUN_BOUND  = 5000;

  logic               clk = 1'b0;
  logic               rst;
  logic               i_gold_wr_en;
  logic [GOLD_AW-1:0] i_gold_wr_addr;
  logic [DW-1:0]      i_gold_wr_din;
  logic               i_start;
  logic [GOLD_AW:0]   i_num_outputs;
  logic               i_out_rdy0, i_out_rdy1;
  logic [DW-1:0]      i_out_dout0, i_out_dout1;
  logic               o_out_rd_en0, o_out_rd_en1;
  logic               o_busy, o_done, o_pass, o_timeout;
  logic [CYCW-1:0]    o_mismatch_cnt;
  logic [GOLD_AW-1:0] o_first_bad;
  logic [CYCW-1:0]    o_cycles;

  npu_out_checker #(
    .EW          (EW),
    .DOTW        (DOTW),
    .GOLD_DEPTH  (GOLD_DEPTH),
    .GOLD_AW     (GOLD_AW),
    .CYCW        (CYCW),
    .TIMEOUT_CYC (TB_TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_gold_wr_en   (i_gold_wr_en),
    .i_gold_wr_addr (i_gold_wr_addr),
    .i_gold_wr_din  (i_gold_wr_din),
    .i_start        (i_start),
    .i_num_outputs  (i_num_outputs),
    .i_out_rdy0     (i_out_rdy0),
    .i_out_rdy1     (i_out_rdy1),
    .i_out_dout0    (i_out_dout0),
    .i_out_dout1    (i_out_dout1),
    .o_out_rd_en0   (o_out_rd_en0),
    .o_out_rd_en1   (o_out_rd_en1),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_pass         (o_pass),
    .o_timeout      (o_timeout),
    .o_mismatch_cnt (o_mismatch_cnt),
    .o_first_bad    (o_first_bad),
    .o_cycles       (o_cycles)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] gold_m [GOLD_DEPTH];
  logic [DW-1:0] lane_q0 [$];
  logic [DW-1:0] lane_q1 [$];

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_vec();
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < DW; i += 32) v[i +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [DW-1:0] flip(input logic [DW-1:0] v);
    logic [DW-1:0] m;
    m = '0;
    m[$urandom_range(0, DW-1)] = 1'b1;
    return v ^ m;
  endfunction

  // Lane readiness schedule; t counts edges with t=0 the start-sampling edge.
  function automatic bit gate(input int mode, input int lane, input int t, input int pops);
    case (mode)
      0:       return 1'b1;
      1:       return ($urandom_range(0, 3) != 0);
      2:       return (lane == 0) ? (t >= 2) : (t >= 5);
      3:       return (pops < 1);
      default: return 1'b1;
    endcase
  endfunction

  task automatic drive_quiet();
    i_start      = 1'b0;
    i_gold_wr_en = 1'b0;
    i_out_rdy0   = 1'b0;
    i_out_rdy1   = 1'b0;
  endtask

  task automatic load_gold(input int first, input int count);
    logic [DW-1:0] d;
    for (int i = first; i < first + count; i++) begin
      @(negedge clk);
      d              = rand_vec();
      i_gold_wr_en   = 1'b1;
      i_gold_wr_addr = GOLD_AW'(i);
      i_gold_wr_din  = d;
      gold_m[i]      = d;
    end
    @(negedge clk);
    i_gold_wr_en = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, " busy"},     o_busy, 0);
    check({name, " done"},     o_done, 0);
    check({name, " pass"},     o_pass, 0);
    check({name, " timeout"},  o_timeout, 0);
    check({name, " mm"},       o_mismatch_cnt, 0);
    check({name, " firstbad"}, o_first_bad, 0);
    check({name, " cycles"},   o_cycles, 0);
    check({name, " rd_en0"},   o_out_rd_en0, 0);
    check({name, " rd_en1"},   o_out_rd_en1, 0);
  endtask

  // One checker run. bad_idx/bad_lane plant a single corruption; rand_bad adds
  // random ones; noise drives ignored starts, dropped golden writes and a
  // changing i_num_outputs while busy; abort_pops >= 0 resets mid-run.
  task automatic run_check(input string name, input int n, input int mode,
                           input int bad_idx, input int bad_lane, input bit rand_bad,
                           input bit noise, input int abort_pops);
    int n_eff, pops, idle, done_t, exp_mm, exp_fb;
    bit to, fin, g0, g1, pop;
    logic [DW-1:0] v0, v1, h0, h1;
    n_eff = (n > GOLD_DEPTH) ? GOLD_DEPTH : n;
    lane_q0.delete();
    lane_q1.delete();
    for (int i = 0; i < n_eff; i++) begin
      v0 = gold_m[i];
      v1 = gold_m[i];
      if (i == bad_idx) begin
        if (bad_lane == 0) v0 = flip(v0); else v1 = flip(v1);
      end
      if (rand_bad && $urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 1) v0 = flip(v0); else v1 = flip(v1);
      end
      lane_q0.push_back(v0);
      lane_q1.push_back(v1);
    end
    pops = 0; idle = 0; done_t = 0; exp_mm = 0; exp_fb = 0; to = 0; fin = 0;
    for (int t = 0; !fin && t < RUN_BOUND; t++) begin
      @(negedge clk);
      i_start       = (t == 0) ? 1'b1 : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
      i_num_outputs = (t == 0 || !noise) ? (GOLD_AW+1)'(n) : (GOLD_AW+1)'($urandom());
      i_gold_wr_en  = noise && (t >= 1);
      i_gold_wr_addr = GOLD_AW'($urandom());
      i_gold_wr_din  = rand_vec();
      g0 = gate(mode, 0, t, pops) && (lane_q0.size() > 0);
      g1 = gate(mode, 1, t, pops) && (lane_q1.size() > 0);
      i_out_rdy0  = g0;
      i_out_rdy1  = g1;
      i_out_dout0 = g0 ? lane_q0[0] : rand_vec();
      i_out_dout1 = g1 ? lane_q1[0] : rand_vec();
      pop = (t >= 2) && g0 && g1;
      #1;
      check($sformatf("%s rd_en0 t%0d", name, t), o_out_rd_en0, pop);
      check($sformatf("%s rd_en1 t%0d", name, t), o_out_rd_en1, pop);
      if (t >= 1) begin
        check($sformatf("%s busy t%0d", name, t), o_busy, 1);
        check($sformatf("%s done t%0d", name, t), o_done, 0);
      end
      if (abort_pops >= 0 && t >= 2 && pops == abort_pops) begin
        rst = 1'b0;
        #1;
        check_all_zero({name, " abort"});
        @(negedge clk);
        drive_quiet();
        check_all_zero({name, " abort held"});
        rst = 1'b1;
        return;
      end
      @(posedge clk);
      if (pop) begin
        h0 = lane_q0.pop_front();
        h1 = lane_q1.pop_front();
        if (h0 != gold_m[pops] || h1 != gold_m[pops]) begin
          if (exp_mm == 0) exp_fb = pops;
          exp_mm++;
        end
        pops++;
        idle = 0;
        if (pops == n_eff) begin fin = 1; done_t = t; end
      end else if (t >= 2) begin
        idle++;
`ifdef NPU_OUT_CHECK_TIMEOUT_EN
        if (idle == TB_TIMEOUT) begin to = 1; fin = 1; done_t = t; end
`endif
      end
      if (t == 1 && n_eff == 0) begin fin = 1; done_t = 1; end
    end
    @(negedge clk);
    drive_quiet();
    if (!fin) check({name, " run bound"}, 0, 1);
    check({name, " done"},     o_done, 1);
    check({name, " busy"},     o_busy, 0);
    check({name, " pass"},     o_pass, (!to && exp_mm == 0));
    check({name, " timeout"},  o_timeout, to);
    check({name, " mm"},       o_mismatch_cnt, exp_mm);
    check({name, " firstbad"}, o_first_bad, exp_fb);
    check({name, " cycles"},   o_cycles, done_t + 1);
    repeat (3) @(negedge clk);
    check({name, " done held"},   o_done, 1);
    check({name, " cycles held"}, o_cycles, done_t + 1);
  endtask

  initial begin
    #1ms;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    rst            = 1'b0;
    i_gold_wr_addr = '0;
    i_gold_wr_din  = '0;
    i_num_outputs  = '0;
    i_out_dout0    = '0;
    i_out_dout1    = '0;
    drive_quiet();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    load_gold(0, GOLD_DEPTH);

    run_check("n4_clean", 4, 0, -1, 0, 0, 0, -1);
    check("n4_clean cycles6", o_cycles, 6);
    run_check("n4_bad_l1_i2", 4, 0, 2, 1, 0, 0, -1);
    check("n4_bad firstbad2", o_first_bad, 2);
    run_check("n3_stagger", 3, 2, -1, 0, 0, 0, -1);
    run_check("n0", 0, 0, -1, 0, 0, 0, -1);
    check("n0 cycles2", o_cycles, 2);
    run_check("abort_idx2", 4, 0, -1, 0, 0, 0, 2);
    run_check("after_abort", 4, 0, -1, 0, 0, 0, -1);
    run_check("n1_bad_l0", 1, 0, 0, 0, 0, 0, -1);

    for (int r = 0; r < 8; r++) begin
      load_gold(0, 48);
      run_check($sformatf("rand%0d", r), $urandom_range(1, 48), 1, -1, 0, 1, 1, -1);
    end

    run_check("clamp600", 600, 0, -1, 0, 0, 0, -1);
    check("clamp600 cycles", o_cycles, GOLD_DEPTH + 2);

`ifdef NPU_OUT_CHECK_TIMEOUT_EN
    run_check("timeout", 2, 3, -1, 0, 0, 0, -1);
    check("timeout flag", o_timeout, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_npu_out_checker

// File: doc/npu_out_checker.md
# npu_out_checker

On-chip result checker downstream of the NPU output loaders. It drains both output ports (`o_ld_out_rd_*` / `o_ld_out_rd_*1`) in lockstep and compares every popped vector on both lanes against a preloaded golden memory. It counts runtime cycles and mismatches and reports pass/fail, so board-level runs self-check without host readback.

## Interface
Parameters:
- `EW`, 8: element width.
- `DOTW`, 40: elements per vector; `DW = EW*DOTW` is derived.
- `GOLD_DEPTH`, 512: golden vector capacity.
- `GOLD_AW`, 9: golden address width, `clog2(GOLD_DEPTH)`.
- `CYCW`, 32: cycle/mismatch counter width.
- `TIMEOUT_CYC`, 65535: watchdog limit; used only with the macro.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `i_gold_wr_en`  in  1  golden write strobe.
- `i_gold_wr_addr`  in  GOLD_AW  golden write address.
- `i_gold_wr_din`  in  DW  golden write data.
- `i_start`  in  1  one-cycle run start.
- `i_num_outputs`  in  GOLD_AW+1  vectors to check; sampled at start.
- `i_out_rdy0`, `i_out_rdy1`  in  1  output loader lanes non-empty (FWFT).
- `i_out_dout0`, `i_out_dout1`  in  DW  output loader head data.
- `o_out_rd_en0`, `o_out_rd_en1`  out  1  pop strobes.
- `o_busy`  out  1  run in progress.
- `o_done`  out  1  run finished; held until next start.
- `o_pass`  out  1  valid when `o_done`.
- `o_timeout`  out  1  watchdog fired.
- `o_mismatch_cnt`  out  CYCW  mismatching vectors.
- `o_first_bad`  out  GOLD_AW  index of first mismatch.
- `o_cycles`  out  CYCW  runtime.

## Operation
- States: IDLE, PREFETCH, RUN, DONE.
- IDLE/DONE with `i_start`=1: go to PREFETCH. Clear counters and `o_first_bad`. Latch `N=i_num_outputs`, `idx=0`. Golden read address = 0.
- PREFETCH: one cycle. Golden[0] lands in `gold_q`. Go to RUN; if N==0, go to DONE with pass=1.
- RUN: `pop = i_out_rdy0 & i_out_rdy1`. Both `o_out_rd_en*` equal `pop`, combinationally.
- On pop, the vector matches only if `i_out_dout0==gold_q` and `i_out_dout1==gold_q`.
- On a mismatch, `o_mismatch_cnt` increments, saturating at all-ones. On the first mismatch, `o_first_bad=idx`.
- Golden read address is `pop ? idx+1 : idx`, so back-to-back pops are supported.
- On the pop with `idx==N-1`: go to DONE, with `o_pass = (mismatch_cnt==0 after this pop)`.
- Only one lane ready: no pop, wait indefinitely (unless the watchdog is compiled in).
- `i_start` in PREFETCH/RUN is ignored.
- Golden writes are accepted only in IDLE/DONE. Writes while `o_busy` are dropped.
- N > GOLD_DEPTH: clamp to GOLD_DEPTH.

## Timing
- Reset values: all outputs 0, state IDLE. The pop strobes are 0 because state is not RUN.
- `o_busy` = state is PREFETCH or RUN, registered.
- `o_done`, `o_pass`, `o_timeout` are registered. They assert on the edge performing the final pop or the timeout, and hold until the next accepted start.
- `o_cycles` counts rising edges from the edge sampling `i_start` (inclusive) to the edge performing the final pop (inclusive). It saturates at all-ones.
  - Example: N=1 with both lanes ready throughout gives `o_cycles`=3.
- Golden RAM has a one-cycle synchronous read. Compare is combinational in the pop cycle, and results register at the same edge.
- Reset mid-run: immediate return to IDLE, all outputs zero. Golden contents are retained (no reset on RAM).

## Configuration
- `NPU_OUT_CHECK_TIMEOUT_EN` defined:
  - A watchdog counts consecutive RUN cycles without a pop.
  - When it reaches `TIMEOUT_CYC`, go to DONE with `o_timeout`=1 and `o_pass`=0. `o_cycles` includes the timeout edge.
  - The watchdog clears on every pop.
- Undefined: no watchdog logic; `o_timeout` is tied 0.

## Structure
- Package `npu_chk_pkg`: state enum `chk_state_e`, plus the `DW` derivation helper.
- Sub-module `npu_chk_gold_ram`: simple dual-port RAM, `GOLD_DEPTH` x `DW`, registered read, no reset.
- All FSM, counter and compare logic stays in `npu_out_checker`.

## Test plan
- Load golden 0..3 = {A,B,C,D}, N=4, both lanes ready continuously with matching data. Expect 4 single-cycle pops, pass=1, mismatch=0, cycles=6.
- N=4 with lane1 vector 2 corrupted. Expect mismatch=1, first_bad=2, pass=0.
- N=3 with lane0 ready at cycle 2 and lane1 ready at cycle 5. Expect no pop before cycle 5 and correct totals.
- N=0 start. Expect DONE 2 edges after start, pass=1, no pops.
- Assert reset during RUN with idx=2. Expect all outputs 0. Restart with N=4 and expect a full re-check passing from idx 0 with golden intact.
- With the macro and TIMEOUT_CYC=16, N=2, one pop then lanes idle. Expect timeout=1 and pass=0 after 16 idle cycles.
